// File: rtl/matrix_stream_feeder.sv
// rtl/matrix_stream_feeder.sv - frame buffer and serial feeder for the 3x3 matrix-inversion collector
//
// Buffers host bytes into whole 18-byte frames (nine 16-bit words, high byte
// first) in a circular RAM of 18*FRAMES entries, then plays each frame out to
// the serial-to-parallel collector: a one-cycle start, 18 consecutive bytes,
// then a wait for the collector's done before the next frame.
//
// Ports:
//   clk                clock
//   rst                asynchronous active-low reset
//   i_in_data          host byte
//   i_in_valid         host byte valid
//   o_in_ready         byte taken on an edge where i_in_valid && o_in_ready
//   i_sp_done          collector done pulse (only honoured while waiting)
//   o_start            one-cycle frame start
//   o_serial_out       registered frame byte stream, 0 outside a frame
//   o_busy             high from the start cycle until done is seen
//   o_frames_pending   complete frames buffered and not yet started
//   o_frame_err        one-cycle pulse on checksum failure
//
// Optional build macro MSF_CHECKSUM_EN: each host frame carries a 19th XOR
// checksum byte that is checked and never stored; a bad frame is discarded.
// Without it frames are 18 bytes and o_frame_err is tied low.

module matrix_stream_feeder #(
    parameter int FRAMES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    i_in_data,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic                          i_sp_done,
    output logic                          o_start,
    output logic [7:0]                    o_serial_out,
    output logic                          o_busy,
    output logic [$clog2(FRAMES+1)-1:0]   o_frames_pending,
    output logic                          o_frame_err
);

    localparam int CAP = 18 * FRAMES;
    localparam int PW  = $clog2(CAP);
    localparam int OW  = $clog2(CAP + 1);
    localparam int FPW = $clog2(FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [7:0]      r_mem [CAP];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [OW-1:0]   r_occ;
    logic [4:0]      r_bcnt;
    logic [4:0]      r_kcnt;
    logic [FPW-1:0]  r_pending;
    logic [7:0]      r_serial;

    logic            w_accept;
    logic            w_store;
    logic            w_ck_phase;
    logic            w_complete;
    logic            w_bad;
    logic            w_rd;
    logic            w_take;
    logic [PW-1:0]   w_rewind;
    logic [4:0]      w_last_idx;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(CAP - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_accept = i_in_valid && o_in_ready;
    assign w_store  = w_accept && !w_ck_phase;
    assign w_rd     = (r_state == S_SEND);
    assign w_take   = (r_state == S_START);

`ifdef MSF_CHECKSUM_EN
    logic [7:0]      r_csum;
    logic [PW-1:0]   r_frame_base;
    logic            r_err;

    assign w_last_idx = 5'd18;
    // Byte 18 of a host frame is the checksum; it is never stored, so the
    // host must be able to deliver it even when the RAM is full.
    assign w_ck_phase = (r_bcnt == 5'd18);
    assign w_complete = w_accept && w_ck_phase && (i_in_data == r_csum);
    assign w_bad      = w_accept && w_ck_phase && (i_in_data != r_csum);
    assign w_rewind   = r_frame_base;
    assign o_frame_err = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum       <= '0;
            r_frame_base <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err <= w_bad;
            if (w_accept) begin
                r_csum <= w_ck_phase ? 8'h00 : (r_csum ^ i_in_data);
            end
            // wr_ptr already points past byte 17 when the checksum arrives
            if (w_complete) begin
                r_frame_base <= r_wr_ptr;
            end
        end
    end
`else
    assign w_last_idx  = 5'd17;
    assign w_ck_phase  = 1'b0;
    assign w_complete  = w_accept && (r_bcnt == 5'd17);
    assign w_bad       = 1'b0;
    assign w_rewind    = r_wr_ptr;
    assign o_frame_err = 1'b0;
`endif

    assign o_in_ready       = w_ck_phase || (r_occ < OW'(CAP));
    assign o_start          = (r_state == S_START);
    assign o_busy           = (r_state != S_IDLE);
    assign o_serial_out     = r_serial;
    assign o_frames_pending = r_pending;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    // Write side: pointer, byte-in-frame counter, occupancy, frame count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_bcnt    <= '0;
            r_occ     <= '0;
            r_pending <= '0;
        end else begin
            if (w_bad) begin
                r_wr_ptr <= w_rewind;
            end else if (w_store) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_accept) begin
                r_bcnt <= (r_bcnt == w_last_idx) ? 5'd0 : r_bcnt + 5'd1;
            end
            r_occ <= r_occ + (w_store ? OW'(1) : OW'(0))
                           - (w_rd ? OW'(1) : OW'(0))
                           - (w_bad ? OW'(18) : OW'(0));
            case ({w_complete, w_take})
                2'b10:   r_pending <= r_pending + FPW'(1);
                2'b01:   r_pending <= r_pending - FPW'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    // Read side: serial_out is loaded one edge ahead so byte k is on the
    // wire during SEND cycle k.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_rd_ptr <= '0;
            r_kcnt   <= '0;
            r_serial <= 8'h00;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_START: begin
                    r_serial <= r_mem[r_rd_ptr];
                    r_kcnt   <= 5'd0;
                end
                S_SEND: begin
                    r_rd_ptr <= f_inc(r_rd_ptr);
                    r_kcnt   <= r_kcnt + 5'd1;
                    r_serial <= (r_kcnt == 5'd17) ? 8'h00 : r_mem[f_inc(r_rd_ptr)];
                end
                default: begin
                    r_serial <= 8'h00;
                end
            endcase
        end
    end

    // WAIT jumps straight to START when another frame is queued so the next
    // start lands in the cycle right after done.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_pending != '0) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                if (r_kcnt == 5'd17) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_sp_done) begin
                    w_next = (r_pending != '0) ? S_START : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
